// File: rtl/mem_axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 memory arbiter.
package mem_axi_arb_pkg;

  localparam int DEF_DW = 128;
  localparam int DEF_AW = 32;
  localparam int DEF_IW = 4;
  // Bit position of the master-select bit in the slave-side ID.
  localparam int MSEL   = DEF_IW;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

endpackage

// File: rtl/mem_axi_arb2_rr_arb2.sv
// Two-request round-robin arbiter: picks a winner when loaded, and remembers
// the last master served so that a tie goes to the other one.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       load,
  input  logic       update,
  output logic       grant
);

  logic last_grant;
  logic pick;

  // Winner: a lone requester wins; on a tie the master not served last wins.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last_grant;
  end

  // Grant is captured on load; last_grant follows it when the transaction ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (load)   grant      <= pick;
      if (update) last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_axi_arb2.sv
// Two-master AXI4 arbiter in front of one memory slave. Reads and writes are
// arbitrated independently, one transaction in flight per direction.
// Handshake rule: a beat transfers on a rising edge where valid and ready are
// both high; only the granted master's channel is ever forwarded.
module mem_axi_arb2
  import mem_axi_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic            clock,
  input  logic            reset,
  // master 0
  input  logic            m0_ar_valid,
  input  logic [IW-1:0]   m0_ar_id,
  input  logic [AW-1:0]   m0_ar_addr,
  input  logic [7:0]      m0_ar_len,
  input  logic [2:0]      m0_ar_size,
  input  logic [1:0]      m0_ar_burst,
  output logic            m0_ar_ready,
  output logic            m0_r_valid,
  output logic [IW-1:0]   m0_r_id,
  output logic [DW-1:0]   m0_r_data,
  output logic [1:0]      m0_r_resp,
  output logic            m0_r_last,
  input  logic            m0_r_ready,
  input  logic            m0_aw_valid,
  input  logic [IW-1:0]   m0_aw_id,
  input  logic [AW-1:0]   m0_aw_addr,
  input  logic [7:0]      m0_aw_len,
  input  logic [2:0]      m0_aw_size,
  input  logic [1:0]      m0_aw_burst,
  output logic            m0_aw_ready,
  input  logic            m0_w_valid,
  input  logic [DW-1:0]   m0_w_data,
  input  logic [DW/8-1:0] m0_w_strb,
  input  logic            m0_w_last,
  output logic            m0_w_ready,
  output logic            m0_b_valid,
  output logic [IW-1:0]   m0_b_id,
  output logic [1:0]      m0_b_resp,
  input  logic            m0_b_ready,
  // master 1
  input  logic            m1_ar_valid,
  input  logic [IW-1:0]   m1_ar_id,
  input  logic [AW-1:0]   m1_ar_addr,
  input  logic [7:0]      m1_ar_len,
  input  logic [2:0]      m1_ar_size,
  input  logic [1:0]      m1_ar_burst,
  output logic            m1_ar_ready,
  output logic            m1_r_valid,
  output logic [IW-1:0]   m1_r_id,
  output logic [DW-1:0]   m1_r_data,
  output logic [1:0]      m1_r_resp,
  output logic            m1_r_last,
  input  logic            m1_r_ready,
  input  logic            m1_aw_valid,
  input  logic [IW-1:0]   m1_aw_id,
  input  logic [AW-1:0]   m1_aw_addr,
  input  logic [7:0]      m1_aw_len,
  input  logic [2:0]      m1_aw_size,
  input  logic [1:0]      m1_aw_burst,
  output logic            m1_aw_ready,
  input  logic            m1_w_valid,
  input  logic [DW-1:0]   m1_w_data,
  input  logic [DW/8-1:0] m1_w_strb,
  input  logic            m1_w_last,
  output logic            m1_w_ready,
  output logic            m1_b_valid,
  output logic [IW-1:0]   m1_b_id,
  output logic [1:0]      m1_b_resp,
  input  logic            m1_b_ready,
  // slave
  output logic            s_ar_valid,
  output logic [IW:0]     s_ar_id,
  output logic [AW-1:0]   s_ar_addr,
  output logic [7:0]      s_ar_len,
  output logic [2:0]      s_ar_size,
  output logic [1:0]      s_ar_burst,
  input  logic            s_ar_ready,
  input  logic            s_r_valid,
  input  logic [IW:0]     s_r_id,
  input  logic [DW-1:0]   s_r_data,
  input  logic [1:0]      s_r_resp,
  input  logic            s_r_last,
  output logic            s_r_ready,
  output logic            s_aw_valid,
  output logic [IW:0]     s_aw_id,
  output logic [AW-1:0]   s_aw_addr,
  output logic [7:0]      s_aw_len,
  output logic [2:0]      s_aw_size,
  output logic [1:0]      s_aw_burst,
  input  logic            s_aw_ready,
  output logic            s_w_valid,
  output logic [DW-1:0]   s_w_data,
  output logic [DW/8-1:0] s_w_strb,
  output logic            s_w_last,
  input  logic            s_w_ready,
  input  logic            s_b_valid,
  input  logic [IW:0]     s_b_id,
  input  logic [1:0]      s_b_resp,
  output logic            s_b_ready,
  output logic            prot_err,
  // state observation
  output logic [1:0]      rd_state,
  output logic [1:0]      wr_state
);

  rd_state_t rstate;
  wr_state_t wstate;
  logic      rg, wg;
  logic [7:0] wlen, cnt;
  logic      ar_hs, r_beat, aw_hs, w_beat, b_beat;

  assign ar_hs  = (rstate == R_ADDR) && s_ar_valid && s_ar_ready;
  assign r_beat = (rstate == R_DATA) && s_r_valid && s_r_ready;
  assign aw_hs  = (wstate == W_ADDR) && s_aw_valid && s_aw_ready;
  assign w_beat = (wstate == W_DATA) && s_w_valid && s_w_ready;
  assign b_beat = (wstate == W_RESP) && s_b_valid && s_b_ready;
  assign rd_state = rstate;
  assign wr_state = wstate;

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({m1_ar_valid, m0_ar_valid}),
    .load   (rstate == R_IDLE),
    .update (r_beat && s_r_last),
    .grant  (rg)
  );

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({m1_aw_valid, m0_aw_valid}),
    .load   (wstate == W_IDLE),
    .update (b_beat),
    .grant  (wg)
  );

  // Read FSM: grant, address handshake, data beats until the last one.
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate <= R_IDLE;
    end else begin
      case (rstate)
        R_IDLE:  if (m0_ar_valid || m1_ar_valid) rstate <= R_ADDR;
        R_ADDR:  if (ar_hs) rstate <= R_DATA;
        R_DATA:  if (r_beat && s_r_last) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: grant, address (latching len), counted data beats, response.
  always_ff @(posedge clock) begin
    if (reset) begin
      wstate <= W_IDLE;
      wlen   <= 8'd0;
      cnt    <= 8'd0;
    end else begin
      case (wstate)
        W_IDLE: if (m0_aw_valid || m1_aw_valid) wstate <= W_ADDR;
        W_ADDR: if (aw_hs) begin
          wlen   <= s_aw_len;
          cnt    <= 8'd0;
          wstate <= W_DATA;
        end
        W_DATA: if (w_beat) begin
          cnt <= cnt + 8'd1;
          if (s_w_last) wstate <= W_RESP;
        end
        W_RESP:  if (b_beat) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Sticky protocol error: wrong returned master bit or W burst length mismatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      prot_err <= 1'b0;
    end else if ((r_beat && (s_r_id[IW] != rg)) ||
                 (b_beat && (s_b_id[IW] != wg)) ||
                 (w_beat && s_w_last && (cnt != wlen)) ||
                 (w_beat && !s_w_last && (cnt == wlen))) begin
      prot_err <= 1'b1;
    end
  end

  // Read path routing: payload muxed by grant, valid/ready gated by state.
  always_comb begin
    s_ar_id     = {rg, rg ? m1_ar_id : m0_ar_id};
    s_ar_addr   = rg ? m1_ar_addr  : m0_ar_addr;
    s_ar_len    = rg ? m1_ar_len   : m0_ar_len;
    s_ar_size   = rg ? m1_ar_size  : m0_ar_size;
    s_ar_burst  = rg ? m1_ar_burst : m0_ar_burst;
    s_ar_valid  = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    m0_r_id     = s_r_id[IW-1:0];
    m1_r_id     = s_r_id[IW-1:0];
    m0_r_data   = s_r_data;
    m1_r_data   = s_r_data;
    m0_r_resp   = s_r_resp;
    m1_r_resp   = s_r_resp;
    m0_r_last   = s_r_last;
    m1_r_last   = s_r_last;
    m0_r_valid  = 1'b0;
    m1_r_valid  = 1'b0;
    s_r_ready   = 1'b0;
    if (rstate == R_ADDR) begin
      s_ar_valid = rg ? m1_ar_valid : m0_ar_valid;
      if (rg) m1_ar_ready = s_ar_ready;
      else    m0_ar_ready = s_ar_ready;
    end
    if (rstate == R_DATA) begin
      s_r_ready = rg ? m1_r_ready : m0_r_ready;
      if (rg) m1_r_valid = s_r_valid;
      else    m0_r_valid = s_r_valid;
    end
  end

  // Write path routing: W is stalled outside W_DATA, B goes to the winner only.
  always_comb begin
    s_aw_id     = {wg, wg ? m1_aw_id : m0_aw_id};
    s_aw_addr   = wg ? m1_aw_addr  : m0_aw_addr;
    s_aw_len    = wg ? m1_aw_len   : m0_aw_len;
    s_aw_size   = wg ? m1_aw_size  : m0_aw_size;
    s_aw_burst  = wg ? m1_aw_burst : m0_aw_burst;
    s_aw_valid  = 1'b0;
    m0_aw_ready = 1'b0;
    m1_aw_ready = 1'b0;
    s_w_data    = wg ? m1_w_data : m0_w_data;
    s_w_strb    = wg ? m1_w_strb : m0_w_strb;
    s_w_last    = wg ? m1_w_last : m0_w_last;
    s_w_valid   = 1'b0;
    m0_w_ready  = 1'b0;
    m1_w_ready  = 1'b0;
    m0_b_id     = s_b_id[IW-1:0];
    m1_b_id     = s_b_id[IW-1:0];
    m0_b_resp   = s_b_resp;
    m1_b_resp   = s_b_resp;
    m0_b_valid  = 1'b0;
    m1_b_valid  = 1'b0;
    s_b_ready   = 1'b0;
    case (wstate)
      W_ADDR: begin
        s_aw_valid = wg ? m1_aw_valid : m0_aw_valid;
        if (wg) m1_aw_ready = s_aw_ready;
        else    m0_aw_ready = s_aw_ready;
      end
      W_DATA: begin
        s_w_valid = wg ? m1_w_valid : m0_w_valid;
        if (wg) m1_w_ready = s_w_ready;
        else    m0_w_ready = s_w_ready;
      end
      W_RESP: begin
        s_b_ready = wg ? m1_b_ready : m0_b_ready;
        if (wg) m1_b_valid = s_b_valid;
        else    m0_b_valid = s_b_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_axi_arb2.sv
// Bench for mem_axi_arb2: table of single transactions, hand-written corner
// sequences, and random arbitration traffic against a round-robin model.
`define CHK(nm, a, e) chk(nm, 128'(a), 128'(e))

module tb_mem_axi_arb2;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IW = 4;

  logic clock, reset;
  logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_last, m0_r_ready;
  logic [IW-1:0] m0_ar_id, m0_r_id, m0_aw_id, m0_b_id;
  logic [AW-1:0] m0_ar_addr, m0_aw_addr;
  logic [7:0] m0_ar_len, m0_aw_len;
  logic [2:0] m0_ar_size, m0_aw_size;
  logic [1:0] m0_ar_burst, m0_aw_burst, m0_r_resp, m0_b_resp;
  logic [DW-1:0] m0_r_data, m0_w_data;
  logic m0_aw_valid, m0_aw_ready, m0_w_valid, m0_w_last, m0_w_ready;
  logic m0_b_valid, m0_b_ready;
  logic [DW/8-1:0] m0_w_strb;
  logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_last, m1_r_ready;
  logic [IW-1:0] m1_ar_id, m1_r_id, m1_aw_id, m1_b_id;
  logic [AW-1:0] m1_ar_addr, m1_aw_addr;
  logic [7:0] m1_ar_len, m1_aw_len;
  logic [2:0] m1_ar_size, m1_aw_size;
  logic [1:0] m1_ar_burst, m1_aw_burst, m1_r_resp, m1_b_resp;
  logic [DW-1:0] m1_r_data, m1_w_data;
  logic m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_last, m1_w_ready;
  logic m1_b_valid, m1_b_ready;
  logic [DW/8-1:0] m1_w_strb;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_last, s_r_ready;
  logic [IW:0] s_ar_id, s_r_id, s_aw_id, s_b_id;
  logic [AW-1:0] s_ar_addr, s_aw_addr;
  logic [7:0] s_ar_len, s_aw_len;
  logic [2:0] s_ar_size, s_aw_size;
  logic [1:0] s_ar_burst, s_aw_burst, s_r_resp, s_b_resp;
  logic [DW-1:0] s_r_data, s_w_data;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_last, s_w_ready;
  logic s_b_valid, s_b_ready;
  logic [DW/8-1:0] s_w_strb;
  logic prot_err;
  logic [1:0] rd_state, wr_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  mem_axi_arb2 #(.DW(DW), .AW(AW), .IW(IW)) dut (
    .clock(clock), .reset(reset),
    .m0_ar_valid(m0_ar_valid), .m0_ar_id(m0_ar_id), .m0_ar_addr(m0_ar_addr),
    .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst),
    .m0_ar_ready(m0_ar_ready), .m0_r_valid(m0_r_valid), .m0_r_id(m0_r_id),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
    .m0_r_ready(m0_r_ready), .m0_aw_valid(m0_aw_valid), .m0_aw_id(m0_aw_id),
    .m0_aw_addr(m0_aw_addr), .m0_aw_len(m0_aw_len), .m0_aw_size(m0_aw_size),
    .m0_aw_burst(m0_aw_burst), .m0_aw_ready(m0_aw_ready), .m0_w_valid(m0_w_valid),
    .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_last(m0_w_last),
    .m0_w_ready(m0_w_ready), .m0_b_valid(m0_b_valid), .m0_b_id(m0_b_id),
    .m0_b_resp(m0_b_resp), .m0_b_ready(m0_b_ready),
    .m1_ar_valid(m1_ar_valid), .m1_ar_id(m1_ar_id), .m1_ar_addr(m1_ar_addr),
    .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst),
    .m1_ar_ready(m1_ar_ready), .m1_r_valid(m1_r_valid), .m1_r_id(m1_r_id),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
    .m1_r_ready(m1_r_ready), .m1_aw_valid(m1_aw_valid), .m1_aw_id(m1_aw_id),
    .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len), .m1_aw_size(m1_aw_size),
    .m1_aw_burst(m1_aw_burst), .m1_aw_ready(m1_aw_ready), .m1_w_valid(m1_w_valid),
    .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last),
    .m1_w_ready(m1_w_ready), .m1_b_valid(m1_b_valid), .m1_b_id(m1_b_id),
    .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_ar_ready(s_ar_ready), .s_r_valid(s_r_valid), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_ready(s_r_ready), .s_aw_valid(s_aw_valid), .s_aw_id(s_aw_id),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_ready(s_aw_ready), .s_w_valid(s_w_valid),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_w_ready(s_w_ready), .s_b_valid(s_b_valid), .s_b_id(s_b_id),
    .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
    .prot_err(prot_err), .rd_state(rd_state), .wr_state(wr_state)
  );

  // clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required $finish before 400000");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Every valid/ready output of the DUT; all must be 0 when both FSMs idle.
  function automatic logic [14:0] vr_vec();
    return {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready,
            m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready,
            m0_w_ready, m1_w_ready, m0_r_valid, m1_r_valid,
            m0_b_valid, m1_b_valid};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_ar_valid = 0; m0_ar_id = '0; m0_ar_addr = '0; m0_ar_len = '0;
    m0_ar_size = 3'd4; m0_ar_burst = 2'd1; m0_r_ready = 0;
    m0_aw_valid = 0; m0_aw_id = '0; m0_aw_addr = '0; m0_aw_len = '0;
    m0_aw_size = 3'd4; m0_aw_burst = 2'd1;
    m0_w_valid = 0; m0_w_data = '0; m0_w_strb = '0; m0_w_last = 0; m0_b_ready = 0;
    m1_ar_valid = 0; m1_ar_id = '0; m1_ar_addr = '0; m1_ar_len = '0;
    m1_ar_size = 3'd4; m1_ar_burst = 2'd1; m1_r_ready = 0;
    m1_aw_valid = 0; m1_aw_id = '0; m1_aw_addr = '0; m1_aw_len = '0;
    m1_aw_size = 3'd4; m1_aw_burst = 2'd1;
    m1_w_valid = 0; m1_w_data = '0; m1_w_strb = '0; m1_w_last = 0; m1_b_ready = 0;
    s_ar_ready = 0; s_r_valid = 0; s_r_id = '0; s_r_data = '0; s_r_resp = '0;
    s_r_last = 0; s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_id = '0;
    s_b_resp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    `CHK("rst_vr", vr_vec(), 15'd0);
    `CHK("rst_rd_state", rd_state, 2'd0);
    `CHK("rst_wr_state", wr_state, 2'd0);
    `CHK("rst_prot_err", prot_err, 1'b0);
    reset = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Requests a read from every master in mask; em is the expected winner.
  task automatic read_txn(input logic [1:0] mask, input logic em,
                          input logic [7:0] len, input bit bad);
    logic [IW-1:0] id0, id1, eid;
    logic [AW-1:0] ea;
    logic [DW-1:0] d, e, got;
    id0 = 4'($urandom_range(0, 15));
    id1 = 4'($urandom_range(0, 15));
    eid = em ? id1 : id0;
    ea  = em ? 32'h1000_0040 : 32'h8000_0000;
    m0_ar_valid = mask[0]; m0_ar_id = id0; m0_ar_addr = 32'h8000_0000; m0_ar_len = len;
    m1_ar_valid = mask[1]; m1_ar_id = id1; m1_ar_addr = 32'h1000_0040; m1_ar_len = len;
    #1;
    `CHK("ar_early", s_ar_valid, 1'b0);
    tick();
    `CHK("ar_valid", s_ar_valid, 1'b1);
    `CHK("ar_id", s_ar_id, {em, eid});
    `CHK("ar_addr", s_ar_addr, ea);
    `CHK("ar_len", s_ar_len, len);
    s_ar_ready = 1;
    #1;
    `CHK("ar_ready", {m1_ar_ready, m0_ar_ready}, em ? 2'b10 : 2'b01);
    tick();
    s_ar_ready = 0; m0_ar_valid = 0; m1_ar_valid = 0;
    m0_r_ready = !em; m1_r_ready = em;
    for (int i = 0; i <= int'(len); i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      s_r_valid = 1; s_r_id = {em ^ bad, eid}; s_r_data = d; s_r_resp = 2'd0;
      s_r_last = (i == int'(len));
      exp_q.push_back(d);
      #1;
      e = exp_q.pop_front();
      `CHK("r_valid", {m1_r_valid, m0_r_valid}, em ? 2'b10 : 2'b01);
      got = em ? m1_r_data : m0_r_data;
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL r_data: got %0h, required %0h (t=%0t)", got, e, $time);
      end
      `CHK("r_id", em ? m1_r_id : m0_r_id, eid);
      `CHK("r_last", em ? m1_r_last : m0_r_last, (i == int'(len)));
      `CHK("s_r_ready", s_r_ready, 1'b1);
      tick();
    end
    s_r_valid = 0; s_r_last = 0; m0_r_ready = 0; m1_r_ready = 0;
    `CHK("rd_back_idle", rd_state, 2'd0);
  endtask

  // Requests a write from every master in mask; the winner sends beats
  // 0..last_at with w_last on beat last_at. pat != 0 gives a fixed fill.
  task automatic write_txn(input logic [1:0] mask, input logic em,
                           input logic [7:0] len, input int last_at,
                           input bit bad, input logic [7:0] pat);
    logic [IW-1:0] id0, id1, eid;
    logic [AW-1:0] ea;
    logic [DW-1:0] d;
    id0 = 4'($urandom_range(0, 15));
    id1 = 4'($urandom_range(0, 15));
    eid = em ? id1 : id0;
    ea  = em ? 32'h2000_0000 : 32'h8000_1000;
    m0_aw_valid = mask[0]; m0_aw_id = id0; m0_aw_addr = 32'h8000_1000; m0_aw_len = len;
    m1_aw_valid = mask[1]; m1_aw_id = id1; m1_aw_addr = 32'h2000_0000; m1_aw_len = len;
    #1;
    `CHK("aw_early", s_aw_valid, 1'b0);
    tick();
    `CHK("aw_valid", s_aw_valid, 1'b1);
    `CHK("aw_id", s_aw_id, {em, eid});
    `CHK("aw_addr", s_aw_addr, ea);
    // W offered before the AW handshake must be held off.
    if (em) m1_w_valid = 1; else m0_w_valid = 1;
    s_w_ready = 1; s_aw_ready = 1;
    #1;
    `CHK("w_stall", {m1_w_ready, m0_w_ready, s_w_valid}, 3'b000);
    `CHK("aw_ready", {m1_aw_ready, m0_aw_ready}, em ? 2'b10 : 2'b01);
    tick();
    s_aw_ready = 0; m0_aw_valid = 0; m1_aw_valid = 0;
    for (int i = 0; i <= last_at; i++) begin
      d = (pat != 8'd0) ? {16{pat}} : {$urandom, $urandom, $urandom, $urandom};
      if (em) begin
        m1_w_valid = 1; m1_w_data = d; m1_w_strb = 16'hFFFF; m1_w_last = (i == last_at);
        m0_w_valid = mask[0]; m0_w_data = ~d; m0_w_strb = 16'h0; m0_w_last = 0;
      end else begin
        m0_w_valid = 1; m0_w_data = d; m0_w_strb = 16'hFFFF; m0_w_last = (i == last_at);
        m1_w_valid = mask[1]; m1_w_data = ~d; m1_w_strb = 16'h0; m1_w_last = 0;
      end
      #1;
      `CHK("s_w_valid", s_w_valid, 1'b1);
      n_cmp++;
      if (s_w_data !== d) begin
        n_bad++;
        $display("FAIL s_w_data: got %0h, required %0h (t=%0t)", s_w_data, d, $time);
      end
      `CHK("s_w_strb", s_w_strb, 16'hFFFF);
      `CHK("s_w_last", s_w_last, (i == last_at));
      `CHK("w_ready", {m1_w_ready, m0_w_ready}, em ? 2'b10 : 2'b01);
      tick();
    end
    m0_w_valid = 0; m1_w_valid = 0; m0_w_last = 0; m1_w_last = 0; s_w_ready = 0;
    s_b_valid = 1; s_b_id = {em ^ bad, eid}; s_b_resp = 2'd0;
    m0_b_ready = !em; m1_b_ready = em;
    #1;
    `CHK("b_valid", {m1_b_valid, m0_b_valid}, em ? 2'b10 : 2'b01);
    `CHK("b_id", em ? m1_b_id : m0_b_id, eid);
    `CHK("b_resp", em ? m1_b_resp : m0_b_resp, 2'd0);
    `CHK("s_b_ready", s_b_ready, 1'b1);
    tick();
    s_b_valid = 0; m0_b_ready = 0; m1_b_ready = 0;
    `CHK("wr_back_idle", wr_state, 2'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         wr;
    logic       m;
    logic [7:0] len;
    int         last_at;
    bit         bad;
    bit         exp_err;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic prev_r, prev_w, em;
    logic [1:0] mask;
    logic [7:0] len;

    reset = 1;
    clear_inputs();

    vt[0] = '{0, 1'b0, 8'd3,   3,   0, 0};  // m0 read len 3
    vt[1] = '{0, 1'b1, 8'd0,   0,   0, 0};  // m1 single-beat read
    vt[2] = '{0, 1'b0, 8'd7,   7,   1, 1};  // slave returns wrong master bit
    vt[3] = '{1, 1'b1, 8'd1,   1,   0, 0};  // m1 write len 1
    vt[4] = '{1, 1'b0, 8'd2,   1,   0, 1};  // w_last one beat early
    vt[5] = '{1, 1'b0, 8'd0,   0,   0, 0};  // single-beat write
    vt[6] = '{1, 1'b1, 8'd1,   2,   0, 1};  // w_last one beat late
    vt[7] = '{1, 1'b0, 8'd3,   3,   1, 1};  // B with wrong master bit
    vt[8] = '{0, 1'b1, 8'd255, 255, 0, 0};  // 256-beat read
    vt[9] = '{1, 1'b0, 8'd255, 255, 0, 0};  // 256-beat write

    for (int v = 0; v < 10; v++) begin
      do_reset();
      if (vt[v].wr)
        write_txn(vt[v].m ? 2'b10 : 2'b01, vt[v].m, vt[v].len, vt[v].last_at, vt[v].bad, 8'd0);
      else
        read_txn(vt[v].m ? 2'b10 : 2'b01, vt[v].m, vt[v].len, vt[v].bad);
      `CHK("vec_prot_err", prot_err, vt[v].exp_err);
    end

    // Ties after reset: m0 first, then m1, on both directions.
    do_reset();
    read_txn(2'b11, 1'b0, 8'd1, 0);
    read_txn(2'b11, 1'b1, 8'd1, 0);
    write_txn(2'b11, 1'b0, 8'd0, 0, 0, 8'd0);
    write_txn(2'b11, 1'b1, 8'd0, 0, 0, 8'd0);

    // m0 read concurrent with m1 write.
    do_reset();
    fork
      read_txn(2'b01, 1'b0, 8'd0, 0);
      write_txn(2'b10, 1'b1, 8'd1, 1, 0, 8'hA5);
    join
    `CHK("conc_prot_err", prot_err, 1'b0);

    // Reset while the third beat of an 8-beat m0 read is on the bus.
    do_reset();
    m0_ar_valid = 1; m0_ar_id = 4'h3; m0_ar_addr = 32'h8000_0100; m0_ar_len = 8'd7;
    tick();
    s_ar_ready = 1;
    tick();
    s_ar_ready = 0; m0_ar_valid = 0;
    s_r_valid = 1; s_r_id = 5'h03; s_r_data = '1; s_r_last = 0; m0_r_ready = 1;
    tick();
    tick();
    `CHK("mid_rd_state", rd_state, 2'd2);
    reset = 1;
    tick();
    `CHK("mid_rst_vr", vr_vec(), 15'd0);
    `CHK("mid_rst_state", rd_state, 2'd0);
    reset = 0; s_r_valid = 0; m0_r_ready = 0;
    read_txn(2'b10, 1'b1, 8'd3, 0);
    `CHK("mid_rst_prot_err", prot_err, 1'b0);

    // Random traffic: the winner of a tie is whoever was not served last.
    do_reset();
    prev_r = 1'b1;
    prev_w = 1'b1;
    for (int k = 0; k < 24; k++) begin
      mask = 2'($urandom_range(1, 3));
      len  = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 0) begin
        em = (mask == 2'b11) ? ~prev_r : mask[1];
        read_txn(mask, em, len, 0);
        prev_r = em;
      end else begin
        em = (mask == 2'b11) ? ~prev_w : mask[1];
        write_txn(mask, em, len, int'(len), 0, 8'd0);
        prev_w = em;
      end
    end
    `CHK("rand_prot_err", prot_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_axi_arb2.md
# mem_axi_arb2

Two-master AXI4 arbiter that shares the single 128-bit memory channel (the `axi_full_slv_sram` port) between the core's `memory_0` master (m0) and a second master (m1: debugger/preload DMA). Read and write paths are arbitrated independently, each round-robin, one transaction in flight per direction. The winner's ID bits carry a master-select bit on the slave side. Sits between `Rift2Chip` and the SRAM slave in the chip/testbench top.

## Interface
- DW, 128, data width of every W/R beat
- AW, 32, address width
- IW, 4, master-side ID width; slave-side ID is IW+1
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- mN_ar_{valid,id,addr,len,size,burst}  in  1,IW,AW,8,3,2  read address from master N (N=0,1)
- mN_ar_ready  out  1  read address accept to master N
- mN_r_{valid,id,data,resp,last}  out  1,IW,DW,2,1  read data to master N
- mN_r_ready  in  1
- mN_aw_{valid,id,addr,len,size,burst}  in  1,IW,AW,8,3,2  write address from master N
- mN_aw_ready  out  1
- mN_w_{valid,data,strb,last}  in  1,DW,DW/8,1  write data from master N
- mN_w_ready  out  1
- mN_b_{valid,id,resp}  out  1,IW,2  write response to master N
- mN_b_ready  in  1
- s_ar_*, s_aw_*, s_w_*, s_r_*, s_b_*  mirror directions  same widths, ids IW+1  slave-side channels
- prot_err  out  1  sticky protocol-error flag, cleared only by reset

## Operation
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE. Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
- IDLE: if any mN_ar_valid (resp. aw_valid), register grant g; both valid -> master != last_grant wins; after reset last_grant=1 so m0 wins first tie.
- ADDR: s_ar_valid = mg_ar_valid; s_ar_id = {g, mg_ar_id}; other fields pass through; mg_ar_ready = s_ar_ready; non-granted ready = 0. On handshake latch len -> DATA.
- R_DATA: s_r routed to mg_r only (other master r_valid=0); s_r_ready = mg_r_ready; strip id MSB. On beat with s_r_last: update last_grant=g, -> R_IDLE.
- W_ADDR as above; W_DATA forwards only mg_w; beat counter cnt (8 bit) increments per W handshake; on w_last handshake -> W_RESP. W_RESP: route s_b to mg_b; on B handshake update last_grant, -> W_IDLE.
- W data presented before AW handshake is stalled (w_ready=0 outside W_DATA).
- prot_err set on: s_r_id MSB != g during R_DATA beat; s_b_id MSB != g; w_last handshake with cnt != latched len; w beat with cnt==len and !w_last. Routing still by g; FSM progresses normally.
- Read and write FSMs fully independent: m0 read concurrent with m1 write is legal.

## Timing
- Reset: all *_valid and *_ready outputs 0, FSMs IDLE, last_grant=1, cnt=0, prot_err=0.
- Grant latency: request visible in IDLE at cycle N -> s_ar_valid/s_aw_valid high at N+1. All later channel signals combinational pass-through (zero added latency per beat).
- IDLE -> IDLE fastest read: 1 (grant) + address handshake + beats; back-to-back transactions insert one IDLE cycle.
- Valid deasserted by master during ADDR (protocol violation): forwarded as-is, no error flag, FSM waits.
- reset asserted mid-burst: all outputs 0 next cycle, transaction abandoned; slave reset concurrently by integration.
- len=0 (single beat) and len=255 (256 beats) both legal; cnt wraps never exceeds 255.

## Structure
- Package mem_axi_arb_pkg: read/write state enums, MSEL bit position constant (IW), default IW/DW.
- One sub-module rr_arb2 (2-request round-robin, registered last_grant, grant output), instanced once per direction.

## Test plan
- m0 AR addr 0x8000_0000 len 3 alone -> s_ar_id=0x0_X with MSB 0, s_ar_valid at cycle+1, 4 R beats only on m0, m1_r_valid stays 0.
- m0 and m1 AR valid same cycle, twice -> first grant m0, second m1; s_ar_id MSB 0 then 1.
- m1 write len 1 data 0xA5.., strb 0xFFFF, concurrent m0 read len 0 -> both complete, B resp 0 on m1, no cross-routing.
- m0 write len 2 with w_last on beat 2 -> prot_err=1, B still delivered to m0, FSM returns W_IDLE.
- slave returns r_id MSB=1 during m0 read -> prot_err=1, data still to m0.
- reset during R_DATA beat 2 of 8 -> next cycle all valid/ready 0, FSM R_IDLE, new m1 read then completes normally.
